// File: rtl/fmt_rx_deframer_pkg.sv
// Shared types for the MCDF formatter receive deframer: FSM states,
// error bit positions and the buffered word layout.
package fmt_rx_deframer_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_GRANT = 2'd1,
    RX_WAIT  = 2'd2,
    RX_RECV  = 2'd3
  } rx_state_t;

  localparam int ERR_PROTO = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_TMO   = 2;

  typedef struct packed {
    logic [1:0]  chid;
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } rx_word_t;

  localparam int RX_WORD_W = $bits(rx_word_t);

endpackage

// File: rtl/fmt_rx_deframer_fifo.sv
// Show-ahead synchronous FIFO: dout presents the head word whenever count!=0.
// Caller guarantees no push when full and no pop when empty.
module rx_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 36
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        din_i,
  input  logic                    pop_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk_i)
    if (push_i) mem[wptr_q] <= din_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + AW'(1);
      if (pop_i)  rptr_q <= rptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Zero when empty so the downstream bus reads idle after reset.
  assign dout_o  = (cnt_q != '0) ? mem[rptr_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/fmt_rx_deframer.sv
// Receives formatter packets into a local buffer, granting only when the
// whole packet fits, and replays them as a SOP..EOP valid/ready stream.
module fmt_rx_deframer
  import fmt_rx_deframer_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 8
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    fmt_req_i,
  input  logic [1:0]              fmt_chid_i,
  input  logic [5:0]              fmt_length_i,
  input  logic [31:0]             fmt_data_i,
  input  logic                    fmt_start_i,
  input  logic                    fmt_end_i,
  output logic                    fmt_grant_o,
  output logic                    rx_vld_o,
  input  logic                    rx_rdy_i,
  output logic [31:0]             rx_data_o,
  output logic [1:0]              rx_chid_o,
  output logic                    rx_sop_o,
  output logic                    rx_eop_o,
  output logic [$clog2(DEPTH):0]  free_o,
  output logic [2:0]              err_o,
  input  logic                    err_clr_i,
  output logic [15:0]             pkt_cnt_o
);
  localparam int FW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  rx_state_t     state_q;
  logic [1:0]    chid_q;
  logic [5:0]    len_q, cnt_q, cnt_nxt;
  logic [TW-1:0] tmo_q;
  logic [FW-1:0] rsv_q, occ, free;
  logic [2:0]    err_q, err_new;
  logic [15:0]   pkt_cnt_q;
  logic          grant_q, push, pop, last, req_ok, tmo_hit;
  rx_word_t      wr_word, rd_word;

  always_comb begin
    push    = 1'b0;
    last    = 1'b0;
    err_new = '0;
    cnt_nxt = cnt_q + 6'd1;
    wr_word = '{chid: chid_q, sop: 1'b0, eop: 1'b0, data: fmt_data_i};
    tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
    req_ok  = fmt_req_i && (fmt_length_i != '0) && (free >= FW'(fmt_length_i));
    case (state_q)
      RX_IDLE, RX_GRANT: err_new[ERR_PROTO] = fmt_start_i;
      RX_WAIT: begin
        if (fmt_start_i) begin
          push        = 1'b1;
          cnt_nxt     = 6'd1;
          wr_word.sop = 1'b1;
        end else begin
          err_new[ERR_TMO] = tmo_hit;
        end
      end
      RX_RECV: begin
        push               = 1'b1;
        err_new[ERR_PROTO] = fmt_start_i;
      end
      default: ;
    endcase
    // A packet closes on fmt_end or on reaching its length; any disagreement
    // between the two is a length error, and the word is always marked EOP.
    if (push) begin
      last             = fmt_end_i || (cnt_nxt == len_q);
      wr_word.eop      = last;
      err_new[ERR_LEN] = last && (fmt_end_i != (cnt_nxt == len_q));
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= RX_IDLE;
      chid_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      rsv_q     <= '0;
      err_q     <= '0;
      pkt_cnt_q <= '0;
      grant_q   <= 1'b0;
    end else begin
      grant_q <= 1'b0;
      err_q   <= (err_clr_i ? 3'b000 : err_q) | err_new;
      case (state_q)
        RX_IDLE: if (req_ok) begin
          chid_q  <= fmt_chid_i;
          len_q   <= fmt_length_i;
          rsv_q   <= FW'(fmt_length_i);
          grant_q <= 1'b1;
          state_q <= RX_GRANT;
        end
        RX_GRANT: begin
          tmo_q   <= '0;
          state_q <= RX_WAIT;
        end
        RX_WAIT: if (!fmt_start_i) begin
          if (tmo_hit) begin
            rsv_q   <= '0;
            state_q <= RX_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: ;
      endcase
      // Each stored word converts one reserved slot into occupancy.
      if (push) begin
        cnt_q <= cnt_nxt;
        if (last) begin
          rsv_q     <= '0;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
          state_q   <= RX_IDLE;
        end else begin
          rsv_q   <= rsv_q - FW'(1);
          state_q <= RX_RECV;
        end
      end
    end
  end

  rx_sync_fifo #(.DEPTH(DEPTH), .WIDTH(RX_WORD_W)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (push),
    .din_i   (wr_word),
    .pop_i   (pop),
    .dout_o  (rd_word),
    .count_o (occ)
  );

  assign free        = FW'(DEPTH) - occ - rsv_q;
  assign rx_vld_o    = (occ != '0);
  assign pop         = rx_rdy_i & rx_vld_o;
  assign rx_data_o   = rd_word.data;
  assign rx_chid_o   = rd_word.chid;
  assign rx_sop_o    = rd_word.sop;
  assign rx_eop_o    = rd_word.eop;
  assign fmt_grant_o = grant_q;
  assign free_o      = free;
  assign err_o       = err_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule

// File: tb/tb_fmt_rx_deframer.sv
// Directed and randomized bench for fmt_rx_deframer; expected stream, errors
// and counters come from a packet-level model (queue of expected words).
module tb_fmt_rx_deframer;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        fmt_req = 1'b0, fmt_start = 1'b0, fmt_end = 1'b0;
  logic [1:0]  fmt_chid = '0;
  logic [5:0]  fmt_length = '0;
  logic [31:0] fmt_data = '0;
  logic        fmt_grant, rx_vld, rx_sop, rx_eop;
  logic        rx_rdy = 1'b0, err_clr = 1'b0;
  logic [31:0] rx_data;
  logic [1:0]  rx_chid;
  logic [6:0]  free;
  logic [2:0]  err;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  fmt_rx_deframer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rstn_i(rst_n),
    .fmt_req_i(fmt_req), .fmt_chid_i(fmt_chid), .fmt_length_i(fmt_length),
    .fmt_data_i(fmt_data), .fmt_start_i(fmt_start), .fmt_end_i(fmt_end),
    .fmt_grant_o(fmt_grant), .rx_vld_o(rx_vld), .rx_rdy_i(rx_rdy),
    .rx_data_o(rx_data), .rx_chid_o(rx_chid), .rx_sop_o(rx_sop), .rx_eop_o(rx_eop),
    .free_o(free), .err_o(err), .err_clr_i(err_clr), .pkt_cnt_o(pkt_cnt)
  );

  int          n_chk = 0, n_pass = 0;
  logic [35:0] exp_q[$];
  int          rdy_mode = 0;   // 0 manual, 1 toggle, 2 random
  int          exp_pkt = 0;
  logic [2:0]  exp_err = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Every accepted output word must be the next one the model expects.
  always @(negedge clk) begin
    if (rst_n && rx_vld && rx_rdy) begin
      chk("rx_word_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0)
        chk("rx_word", {rx_chid, rx_sop, rx_eop, rx_data}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    case (rdy_mode)
      1:       rx_rdy = ~rx_rdy;
      2:       rx_rdy = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic chk_reset();
    chk("rst_grant", fmt_grant, 0);
    chk("rst_vld", rx_vld, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_chid", rx_chid, 0);
    chk("rst_sop", rx_sop, 0);
    chk("rst_eop", rx_eop, 0);
    chk("rst_free", free, DEPTH);
    chk("rst_err", err, 0);
    chk("rst_pkt", pkt_cnt, 0);
  endtask

  // Request a packet and wait (bounded) for the one-cycle grant.
  task automatic do_req(input logic [1:0] ch, input int len, input int bound, output int waited);
    fmt_req = 1'b1; fmt_chid = ch; fmt_length = 6'(len); waited = 0;
    do begin tick(); waited++; end while (!fmt_grant && waited < bound);
    fmt_req = 1'b0;
    chk("grant_seen", fmt_grant, 1);
    tick();
    chk("grant_one_cycle", fmt_grant, 0);
  endtask

  // Formatter side of one granted packet; end_at=0 means no fmt_end at all.
  task automatic send_words(input logic [1:0] ch, input int len, input int end_at,
                            input int delay, input int n_words);
    int eff;
    eff = (end_at != 0 && end_at < len) ? end_at : len;
    if (delay >= TIMEOUT) exp_err[2] = 1'b1;
    else if (n_words >= eff) begin
      exp_pkt++;
      if (end_at != len) exp_err[1] = 1'b1;
    end
    repeat (delay) begin fmt_data = $urandom; tick(); end
    for (int i = 1; i <= n_words; i++) begin
      fmt_data = $urandom; fmt_start = (i == 1); fmt_end = (i == end_at);
      if (i <= eff) exp_q.push_back({ch, 1'(i == 1), 1'(i == eff), fmt_data});
      tick();
    end
    fmt_start = 1'b0; fmt_end = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || rx_vld) && n < bound) begin tick(); n++; end
    chk("drain_done", (exp_q.size() == 0) && !rx_vld, 1);
  endtask

  task automatic clear_err();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    exp_err = '0;
    chk("err_cleared", err, exp_err);
  endtask

  initial begin
    int w, g, len, end_at, nw, r;
    logic [1:0] ch;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    rst_n = 1'b1;
    tick();

    // Basic 8-word packet, chid 2
    rx_rdy = 1'b1;
    do_req(2'd2, 8, 4, w);
    chk("t1_grant_latency", w, 1);
    send_words(2'd2, 8, 8, 0, 8);
    drain(50);
    chk("t1_pkt", pkt_cnt, exp_pkt);
    chk("t1_err", err, exp_err);
    chk("t1_free", free, DEPTH);

    // Fill the buffer, then a 4-word request waits for 4 pops
    rx_rdy = 1'b0;
    do_req(2'd0, 32, 4, w);
    send_words(2'd0, 32, 32, 0, 32);
    do_req(2'd1, 32, 4, w);
    send_words(2'd1, 32, 32, 0, 32);
    chk("t2_free_full", free, DEPTH - exp_q.size());
    fmt_req = 1'b1; fmt_chid = 2'd3; fmt_length = 6'd4; g = 0;
    repeat (10) begin tick(); g |= int'(fmt_grant); end
    chk("t2_no_grant_full", g, 0);
    rx_rdy = 1'b1;
    repeat (4) tick();
    rx_rdy = 1'b0;
    do_req(2'd3, 4, 4, w);
    chk("t2_grant_after_pop", w, 1);
    send_words(2'd3, 4, 4, 0, 4);
    rx_rdy = 1'b1;
    drain(200);
    chk("t2_free", free, DEPTH);
    chk("t2_pkt", pkt_cnt, exp_pkt);

    // Early end and missing end
    do_req(2'd1, 16, 4, w);
    send_words(2'd1, 16, 10, 0, 10);
    drain(50);
    chk("t3_err_trunc", err, exp_err);
    chk("t3_pkt_trunc", pkt_cnt, exp_pkt);
    clear_err();
    do_req(2'd2, 16, 4, w);
    send_words(2'd2, 16, 0, 0, 20);
    drain(50);
    chk("t3_err_forced", err, exp_err);
    chk("t3_free_forced", free, DEPTH);
    clear_err();

    // Start timeout, start at the last allowed cycle, start in IDLE
    do_req(2'd0, 8, 4, w);
    send_words(2'd0, 8, 8, TIMEOUT, 0);
    chk("t4_err_tmo", err, exp_err);
    chk("t4_free_tmo", free, DEPTH);
    chk("t4_vld_tmo", rx_vld, 0);
    chk("t4_pkt_tmo", pkt_cnt, exp_pkt);
    clear_err();
    do_req(2'd1, 4, 4, w);
    send_words(2'd1, 4, 4, TIMEOUT - 1, 4);
    drain(50);
    chk("t4_late_start_err", err, exp_err);
    chk("t4_late_start_pkt", pkt_cnt, exp_pkt);
    fmt_start = 1'b1; tick(); fmt_start = 1'b0;
    exp_err[0] = 1'b1;
    chk("t4_err_proto", err, exp_err);
    err_clr = 1'b1; fmt_start = 1'b1; tick(); err_clr = 1'b0; fmt_start = 1'b0;
    exp_err = 3'b001;
    chk("t5_clr_new_wins", err, exp_err);
    clear_err();

    // Ready toggling across a 32-word packet
    rdy_mode = 1;
    do_req(2'd3, 32, 4, w);
    send_words(2'd3, 32, 32, 0, 32);
    drain(200);
    chk("t5_err", err, exp_err);
    chk("t5_pkt", pkt_cnt, exp_pkt);

    // Reset on word 5 of 16
    rdy_mode = 0; rx_rdy = 1'b1;
    do_req(2'd2, 16, 4, w);
    send_words(2'd2, 16, 16, 0, 4);
    fmt_data = $urandom;
    #2 rst_n = 1'b0;
    exp_q.delete(); exp_pkt = 0; exp_err = '0;
    #1 chk_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_req(2'd1, 8, 4, w);
    send_words(2'd1, 8, 8, 0, 8);
    drain(50);
    chk("t6_pkt", pkt_cnt, exp_pkt);
    chk("t6_err", err, exp_err);

    // Randomized packets with random backpressure
    rdy_mode = 2;
    for (int p = 0; p < 16; p++) begin
      ch  = 2'($urandom_range(0, 3));
      len = 4 << $urandom_range(0, 3);
      r   = $urandom_range(0, 9);
      if (r < 7)      begin end_at = len; nw = len; end
      else if (r < 9) begin end_at = $urandom_range(1, len - 1); nw = end_at; end
      else            begin end_at = 0; nw = len + $urandom_range(0, 3); end
      do_req(ch, len, 400, w);
      send_words(ch, len, end_at, $urandom_range(0, TIMEOUT - 1), nw);
      chk("rnd_pkt", pkt_cnt, exp_pkt);
      chk("rnd_err", err, exp_err);
      chk("rnd_free", free, DEPTH - exp_q.size());
    end
    drain(1000);
    chk("rnd_free_end", free, DEPTH);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
